// File: rtl/sram_async_ctrl.sv
// Single-outstanding request/response controller for asynchronous CMOS SRAMs.
// Strobe timing is counted in clock cycles; all SRAM-side outputs come straight from flops.
module sram_async_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int T_AS   = 1,
  parameter int T_RD   = 5,
  parameter int T_WP   = 3,
  parameter int T_DH   = 1,
  parameter int T_TURN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_e_n,
  output logic              sram_g_n,
  output logic              sram_w_n,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i
);

  if (T_AS < 1 || T_RD < 1 || T_WP < 1 || T_DH < 1 || T_TURN < 1) begin : g_param_check
    $fatal(1, "sram_async_ctrl: all timing parameters must be >= 1");
  end

  localparam int T_M0  = (T_AS > T_RD) ? T_AS : T_RD;
  localparam int T_M1  = (T_M0 > T_WP) ? T_M0 : T_WP;
  localparam int T_M2  = (T_M1 > T_DH) ? T_M1 : T_DH;
  localparam int T_MAX = (T_M2 > T_TURN) ? T_M2 : T_TURN;
  localparam int CNT_W = $clog2(T_MAX) + 1;

  // Counter is loaded with (T - 1) on state entry; the state ends on the edge where it reads zero.
  localparam logic [CNT_W-1:0] LD_AS   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_RD   = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] LD_WP   = CNT_W'(T_WP - 1);
  localparam logic [CNT_W-1:0] LD_DH   = CNT_W'(T_DH - 1);
  localparam logic [CNT_W-1:0] LD_TURN = CNT_W'(T_TURN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD_ACC,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RECOVER
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              busy_q;
  logic              e_n_q;
  logic              g_n_q;
  logic              w_n_q;
  logic              dq_oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_o_q;
  logic [DATA_W-1:0] rdata_q;
  logic              last;

  assign last = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      e_n_q       <= 1'b1;
      g_n_q       <= 1'b1;
      w_n_q       <= 1'b1;
      dq_oe_q     <= 1'b0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      cnt_q       <= cnt_q - CNT_W'(1);
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            e_n_q       <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= LD_AS;
            if (req_we) begin
              dq_o_q  <= req_wdata;
              dq_oe_q <= 1'b1;
              state_q <= S_WR_SETUP;
            end else begin
              state_q <= S_RD_SETUP;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_RD_SETUP: begin
          if (last) begin
            g_n_q   <= 1'b0;
            cnt_q   <= LD_RD;
            state_q <= S_RD_ACC;
          end
        end
        S_RD_ACC: begin
          if (last) begin
            rdata_q     <= sram_dq_i;
            rsp_valid_q <= 1'b1;
            g_n_q       <= 1'b1;
            e_n_q       <= 1'b1;
            cnt_q       <= LD_TURN;
            state_q     <= S_RECOVER;
          end
        end
        S_WR_SETUP: begin
          if (last) begin
            w_n_q   <= 1'b0;
            cnt_q   <= LD_WP;
            state_q <= S_WR_PULSE;
          end
        end
        S_WR_PULSE: begin
          if (last) begin
            w_n_q   <= 1'b1;
            cnt_q   <= LD_DH;
            state_q <= S_WR_HOLD;
          end
        end
        S_WR_HOLD: begin
          // Address and data stay put through the hold window; the bus is released only at its end.
          if (last) begin
            dq_oe_q     <= 1'b0;
            e_n_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            cnt_q       <= LD_TURN;
            state_q     <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (last) begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign busy       = busy_q;
  assign sram_addr  = addr_q;
  assign sram_e_n   = e_n_q;
  assign sram_g_n   = g_n_q;
  assign sram_w_n   = w_n_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: default and alternate-timing instances, each against a small SRAM model.
`timescale 1ns/1ps
module tb_sram_async_ctrl;

  localparam int LAT_R = 6;
  localparam int LAT_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Default-parameter instance
  logic        req_valid, req_ready, req_we, rsp_valid, busy;
  logic [10:0] req_addr, s_addr;
  logic [7:0]  req_wdata, rsp_rdata, s_dq_o, s_dq_i;
  logic        s_e_n, s_g_n, s_w_n, s_dq_oe;

  sram_async_ctrl u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sram_addr(s_addr), .sram_e_n(s_e_n), .sram_g_n(s_g_n), .sram_w_n(s_w_n),
    .sram_dq_o(s_dq_o), .sram_dq_oe(s_dq_oe), .sram_dq_i(s_dq_i)
  );

  // Alternate-timing instance
  logic        p_req_valid, p_req_ready, p_req_we, p_rsp_valid, p_busy;
  logic [15:0] p_req_addr, p_s_addr, p_req_wdata, p_rsp_rdata, p_s_dq_o, p_s_dq_i;
  logic        p_e_n, p_g_n, p_w_n, p_dq_oe;

  sram_async_ctrl #(
    .ADDR_W(16), .DATA_W(16), .T_AS(2), .T_RD(2), .T_WP(4), .T_DH(2), .T_TURN(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_we(p_req_we),
    .req_addr(p_req_addr), .req_wdata(p_req_wdata),
    .rsp_valid(p_rsp_valid), .rsp_rdata(p_rsp_rdata), .busy(p_busy),
    .sram_addr(p_s_addr), .sram_e_n(p_e_n), .sram_g_n(p_g_n), .sram_w_n(p_w_n),
    .sram_dq_o(p_s_dq_o), .sram_dq_oe(p_dq_oe), .sram_dq_i(p_s_dq_i)
  );

  // SRAM models: unwritten words read as all ones, bus floats high when not driven
  bit [7:0]  m0_mem [2048];
  bit        m0_wr  [2048];
  bit [15:0] m1_mem [65536];
  bit        m1_wr  [65536];

  always @(posedge clk) begin
    if (!s_e_n && !s_w_n && s_dq_oe) begin
      m0_mem[s_addr] <= s_dq_o;
      m0_wr[s_addr]  <= 1'b1;
    end
    if (!p_e_n && !p_w_n && p_dq_oe) begin
      m1_mem[p_s_addr] <= p_s_dq_o;
      m1_wr[p_s_addr]  <= 1'b1;
    end
  end

  assign s_dq_i   = (!s_e_n && !s_g_n && m0_wr[s_addr]) ? m0_mem[s_addr] : 8'hFF;
  assign p_s_dq_i = (!p_e_n && !p_g_n && m1_wr[p_s_addr]) ? m1_mem[p_s_addr] : 16'hFFFF;

  // Bus-protocol invariant monitor
  logic [10:0] prev_addr;
  logic [15:0] p_prev_addr;
  logic        prev_e_low, p_prev_e_low;
  int          inv_bad = 0;
  wire inv_viol = (!s_g_n && !s_w_n) || (s_dq_oe && !s_g_n) || (!s_w_n && s_e_n) ||
                  (prev_e_low && !s_e_n && (s_addr != prev_addr)) ||
                  (!p_g_n && !p_w_n) || (p_dq_oe && !p_g_n) || (!p_w_n && p_e_n) ||
                  (p_prev_e_low && !p_e_n && (p_s_addr != p_prev_addr));

  always @(negedge clk) begin
    prev_addr    <= s_addr;
    prev_e_low   <= !s_e_n;
    p_prev_addr  <= p_s_addr;
    p_prev_e_low <= !p_e_n;
    if (inv_viol) inv_bad <= inv_bad + 1;
  end

  // Scoreboard for the default instance
  bit         sb_we  [$];
  logic [7:0] sb_dat [$];
  int         sb_cyc [$];
  logic [7:0] sh_mem [2048];
  bit         sh_wr  [2048];
  logic [15:0] p_sb [$];

  task automatic sb_push(input bit we, input logic [10:0] a, input logic [7:0] d);
    sb_we.push_back(we);
    sb_dat.push_back(we ? 8'h00 : (sh_wr[a] ? sh_mem[a] : 8'hFF));
    sb_cyc.push_back(cyc + 1 + (we ? LAT_W : LAT_R));
    if (we) begin
      sh_mem[a] = d;
      sh_wr[a]  = 1'b1;
    end
  endtask

  task automatic sb_pop(output bit emp, output bit we, output logic [7:0] d, output int c);
    emp = (sb_we.size() == 0);
    we = 1'b0; d = '0; c = 0;
    if (!emp) begin
      we = sb_we.pop_front();
      d  = sb_dat.pop_front();
      c  = sb_cyc.pop_front();
    end
  endtask

  // Present a request at a negedge and hold it until accepted; returns at the negedge after acceptance
  task automatic issue(input bit we, input logic [10:0] a, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        sb_push(we, a, d);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %0b want 0", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rsp_rdata: got %0h want 0", rsp_rdata); end
    n_cmp++; if (s_addr !== 11'h000) begin n_err++; $display("FAIL rst_addr: got %0h want 0", s_addr); end
    n_cmp++; if ({s_e_n, s_g_n, s_w_n} !== 3'b111) begin n_err++; $display("FAIL rst_strobes: got %b want 111", {s_e_n, s_g_n, s_w_n}); end
    n_cmp++; if (s_dq_oe !== 1'b0) begin n_err++; $display("FAIL rst_dq_oe: got %0b want 0", s_dq_oe); end
    n_cmp++; if (s_dq_o !== 8'h00) begin n_err++; $display("FAIL rst_dq_o: got %0h want 0", s_dq_o); end
    n_cmp++; if (p_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_p_req_ready: got %0b want 0", p_req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %0b want 1", req_ready); end
    n_cmp++; if (p_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_p_ready: got %0b want 1", p_req_ready); end
  endtask

  task automatic test_write_defaults();
    bit ok, got, emp, ew; logic [7:0] ed; int ec, w_lo, oe_hi;
    issue(1'b1, 11'h123, 8'hA5, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL wr_accept: got %0b want 1", ok); end
    w_lo = 0; oe_hi = 0; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin got = 1'b1; break; end
      if (!s_w_n) w_lo++;
      if (s_dq_oe) oe_hi++;
      @(negedge clk);
    end
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL wr_rsp: got %0b want 1", got); end
    n_cmp++; if (w_lo !== 3) begin n_err++; $display("FAIL wr_w_low_cycles: got %0d want 3", w_lo); end
    n_cmp++; if (oe_hi !== 5) begin n_err++; $display("FAIL wr_oe_cycles: got %0d want 5", oe_hi); end
    if (got) begin
      sb_pop(emp, ew, ed, ec);
      n_cmp++; if (emp !== 1'b0) begin n_err++; $display("FAIL wr_sb: scoreboard empty got %0b want 0", emp); end
      n_cmp++; if (cyc !== ec) begin n_err++; $display("FAIL wr_latency: rsp at cycle %0d want %0d", cyc, ec); end
    end
  endtask

  task automatic test_read_at(input logic [10:0] a, input string tag);
    bit ok, got, emp, ew; logic [7:0] ed; int ec, g_lo, oe_g;
    issue(1'b0, a, 8'h00, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL %s_accept: got %0b want 1", tag, ok); end
    g_lo = 0; oe_g = 0; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin got = 1'b1; break; end
      if (!s_g_n) g_lo++;
      if (!s_g_n && s_dq_oe) oe_g++;
      @(negedge clk);
    end
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL %s_rsp: got %0b want 1", tag, got); end
    n_cmp++; if (g_lo !== 5) begin n_err++; $display("FAIL %s_g_low_cycles: got %0d want 5", tag, g_lo); end
    n_cmp++; if (oe_g !== 0) begin n_err++; $display("FAIL %s_oe_with_g: got %0d want 0", tag, oe_g); end
    if (got) begin
      sb_pop(emp, ew, ed, ec);
      n_cmp++; if (emp !== 1'b0) begin n_err++; $display("FAIL %s_sb: scoreboard empty got %0b want 0", tag, emp); end
      n_cmp++; if (cyc !== ec) begin n_err++; $display("FAIL %s_latency: rsp at cycle %0d want %0d", tag, cyc, ec); end
      n_cmp++; if (rsp_rdata !== ed) begin n_err++; $display("FAIL %s_rdata: got %0h want %0h", tag, rsp_rdata, ed); end
    end
  endtask

  task automatic test_back_to_back();
    int acc[8]; int na, nr, e_run, ec; bit pend, seen_low, emp, ew; logic [7:0] ed;
    acc = '{default: 0};
    na = 0; nr = 0; e_run = 0; pend = 1'b1; seen_low = 1'b0;
    for (int i = 0; i < 200 && nr < 8; i++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (na < 8) begin
          req_valid = 1'b1; req_we = (na < 4); req_addr = 11'(na % 4); req_wdata = 8'hC0 + 8'(na);
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        nr++;
        sb_pop(emp, ew, ed, ec);
        n_cmp++; if (cyc !== ec) begin n_err++; $display("FAIL b2b_latency: rsp %0d at cycle %0d want %0d", nr, cyc, ec); end
        if (!ew) begin
          n_cmp++; if (rsp_rdata !== ed) begin n_err++; $display("FAIL b2b_rdata: rsp %0d got %0h want %0h", nr, rsp_rdata, ed); end
        end
      end
      if (s_e_n) begin
        e_run++;
      end else begin
        if (seen_low && e_run > 0) begin
          n_cmp++; if (e_run < 3) begin n_err++; $display("FAIL b2b_e_gap: got %0d cycles want >=3", e_run); end
        end
        seen_low = 1'b1;
        e_run = 0;
      end
      if (req_valid && req_ready && na < 8) begin
        acc[na] = cyc + 1;
        sb_push(req_we, req_addr, req_wdata);
        na++;
        pend = 1'b1;
      end
    end
    req_valid = 1'b0;
    n_cmp++; if (nr !== 8) begin n_err++; $display("FAIL b2b_rsp_count: got %0d want 8", nr); end
    for (int k = 1; k < 8; k++) begin
      n_cmp++;
      if (acc[k] - acc[k-1] !== ((k < 5) ? 9 : 10)) begin
        n_err++; $display("FAIL b2b_spacing: accept %0d spacing %0d want %0d", k, acc[k] - acc[k-1], (k < 5) ? 9 : 10);
      end
    end
  endtask

  task automatic test_ignore_during_read();
    bit ok, got, emp, ew; logic [7:0] ed; int ec, moved, extra;
    issue(1'b0, 11'h002, 8'h00, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ign_accept: got %0b want 1", ok); end
    for (int k = 0; k < 10 && s_g_n; k++) @(negedge clk);
    moved = 0; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin got = 1'b1; break; end
      if (s_addr !== 11'h002) moved++;
      req_valid = ~req_valid; req_we = 1'($urandom); req_addr = 11'($urandom); req_wdata = 8'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL ign_rsp: got %0b want 1", got); end
    n_cmp++; if (moved !== 0) begin n_err++; $display("FAIL ign_addr_moved: got %0d cycles want 0", moved); end
    if (got) begin
      sb_pop(emp, ew, ed, ec);
      n_cmp++; if (cyc !== ec) begin n_err++; $display("FAIL ign_latency: rsp at cycle %0d want %0d", cyc, ec); end
      n_cmp++; if (rsp_rdata !== ed) begin n_err++; $display("FAIL ign_rdata: got %0h want %0h", rsp_rdata, ed); end
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ign_extra_rsp: got %0d want 0", extra); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy: got %0b want 0", busy); end
    n_cmp++; if (s_addr !== 11'h002) begin n_err++; $display("FAIL ign_addr_hold: got %0h want 002", s_addr); end
  endtask

  task automatic test_reset_mid_write();
    bit ok; int nrsp;
    issue(1'b1, 11'h055, 8'h3C, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rmw_accept: got %0b want 1", ok); end
    for (int k = 0; k < 10 && s_w_n; k++) @(negedge clk);
    n_cmp++; if (s_w_n !== 1'b0) begin n_err++; $display("FAIL rmw_pulse_seen: w_n got %0b want 0", s_w_n); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({s_e_n, s_g_n, s_w_n} !== 3'b111) begin n_err++; $display("FAIL rmw_strobes: got %b want 111", {s_e_n, s_g_n, s_w_n}); end
    n_cmp++; if (s_dq_oe !== 1'b0) begin n_err++; $display("FAIL rmw_dq_oe: got %0b want 0", s_dq_oe); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rmw_ready: got %0b want 1", req_ready); end
    nrsp = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) nrsp++;
      @(negedge clk);
    end
    n_cmp++; if (nrsp !== 0) begin n_err++; $display("FAIL rmw_no_rsp: got %0d pulses want 0", nrsp); end
    n_cmp++; if (sb_we.size() !== 1) begin n_err++; $display("FAIL rmw_sb_left: got %0d entries want 1", sb_we.size()); end
    sb_we.delete(); sb_dat.delete(); sb_cyc.delete();
  endtask

  task automatic test_param_config();
    bit ok, got; int acc, w_lo; logic [15:0] ed;
    @(negedge clk);
    p_req_valid = 1'b1; p_req_we = 1'b1; p_req_addr = 16'hFFFF; p_req_wdata = 16'hBEEF;
    ok = 1'b0; acc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (p_req_ready) begin ok = 1'b1; acc = cyc + 1; end
      @(negedge clk);
    end
    p_req_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL p_wr_accept: got %0b want 1", ok); end
    w_lo = 0; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (p_rsp_valid) begin got = 1'b1; break; end
      if (!p_w_n) w_lo++;
      @(negedge clk);
    end
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL p_wr_rsp: got %0b want 1", got); end
    n_cmp++; if (w_lo !== 4) begin n_err++; $display("FAIL p_w_low_cycles: got %0d want 4", w_lo); end
    n_cmp++; if (cyc - acc !== 8) begin n_err++; $display("FAIL p_wr_latency: got %0d want 8", cyc - acc); end
    @(negedge clk);
    p_req_valid = 1'b1; p_req_we = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (p_req_ready) begin ok = 1'b1; acc = cyc + 1; p_sb.push_back(16'hBEEF); end
      @(negedge clk);
    end
    p_req_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL p_rd_accept: got %0b want 1", ok); end
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (p_rsp_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL p_rd_rsp: got %0b want 1", got); end
    if (got && p_sb.size() > 0) begin
      ed = p_sb.pop_front();
      n_cmp++; if (p_rsp_rdata !== ed) begin n_err++; $display("FAIL p_rdata: got %0h want %0h", p_rsp_rdata, ed); end
      n_cmp++; if (cyc - acc !== 4) begin n_err++; $display("FAIL p_rd_latency: got %0d want 4", cyc - acc); end
    end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (inv_bad !== 0) begin n_err++; $display("FAIL bus_invariants: got %0d violating cycles want 0", inv_bad); end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    p_req_valid = 1'b0; p_req_we = 1'b0; p_req_addr = '0; p_req_wdata = '0;
    test_reset();
    test_write_defaults();
    test_read_at(11'h123, "rd_back");
    test_read_at(11'h7FF, "rd_unwritten");
    test_back_to_back();
    test_ignore_during_read();
    test_reset_mid_write();
    test_param_config();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_async_ctrl.md
Name: sram_async_ctrl

Overview:
- Synchronous, parametrised controller for asynchronous CMOS static RAMs of the HM-65162 class, generalised in address width, data width and strobe timing.
- Turns a single-outstanding request/response interface into correctly timed E/G/W strobe sequences, with the data bus split into out, out-enable and in.
- The top level owns the tristate pad.
- Timing is expressed in clock cycles so one RTL serves any SRAM speed grade or system clock. The existing behavioural SRAM model is the bench target.

Parameters:
ADDR_W, 11, SRAM address width (11 = 2K words)
DATA_W, 8, SRAM data width
T_AS, 1, cycles address/E valid before G or W falls (>=1)
T_RD, 5, cycles G low before read data is sampled (>=1; covers tAVQV/tGLQV)
T_WP, 3, cycles W held low (>=1; covers tWLWH)
T_DH, 1, cycles data and address held after W rises (>=1; covers tWHDX/tWHAX)
T_TURN, 3, cycles E/G high before next access (>=1; covers tEHQZ/tGHQZ)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  request present
req_ready  out  1  controller can accept request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: read data valid / write complete
rsp_rdata  out  DATA_W  read data, held until next read completes
busy  out  1  controller not in IDLE
sram_addr  out  ADDR_W  SRAM address
sram_e_n  out  1  chip enable, active low
sram_g_n  out  1  output enable, active low
sram_w_n  out  1  write enable, active low
sram_dq_o  out  DATA_W  data driven to SRAM
sram_dq_oe  out  1  1 = top level drives sram_dq_o onto bus
sram_dq_i  in  DATA_W  data bus sampled from SRAM

Behaviour:
- All outputs registered; no combinational path from req_* to sram_* (glitch-free strobes).
- Reset values, applied asynchronously: sram_e_n=1, sram_g_n=1, sram_w_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, rsp_valid=0, rsp_rdata=0, req_ready=0, busy=0.
- First cycle after rst_n deasserts: state IDLE, req_ready=1.
- States: IDLE, RD_SETUP, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, RECOVER. A down-counter of width clog2(max T)+1 is loaded on every state entry.
- IDLE: req_ready=1, all strobes high.
  - On req_valid&req_ready at edge k, latch addr/wdata/we.
  - At k, sram_addr<=req_addr, sram_e_n<=0, req_ready<=0, busy<=1.
  - Enter RD_SETUP or WR_SETUP.
- RD_SETUP: T_AS cycles, G high. Then RD_ACC.
- RD_ACC: sram_g_n=0 for T_RD cycles.
  - On the edge ending the last cycle, rsp_rdata<=sram_dq_i, rsp_valid<=1, sram_g_n<=1, sram_e_n<=1. Enter RECOVER.
- WR_SETUP: sram_dq_oe=1, sram_dq_o=latched data, W high, T_AS cycles. Then WR_PULSE.
- WR_PULSE: sram_w_n=0 for T_WP cycles. Then WR_HOLD.
- WR_HOLD: W high; addr, dq_o and dq_oe unchanged for T_DH cycles.
  - On the ending edge: sram_dq_oe<=0, sram_e_n<=1, rsp_valid<=1. Enter RECOVER.
- RECOVER: all strobes high, T_TURN cycles. rsp_valid is high only in its first cycle. Then IDLE with req_ready=1.
- sram_addr holds its last value in RECOVER and IDLE.
- Latency from the accept edge to the rsp_valid cycle:
  - read = T_AS+T_RD cycles;
  - write = T_AS+T_WP+T_DH cycles.
- Throughput: read every T_AS+T_RD+T_TURN+1 cycles; write every T_AS+T_WP+T_DH+T_TURN+1 cycles.
- Invariants the bench asserts every cycle:
  - G and W never low simultaneously;
  - dq_oe never 1 while G low;
  - W low only while E low;
  - sram_addr constant whenever E is low.
- req_valid while req_ready=0 is ignored. The requester holds the request; nothing is queued.
- Reset mid-operation (including during WR_PULSE): strobes go high and dq_oe goes 0 immediately. The SRAM word is undefined and no rsp_valid is issued.
- Any parameter value <1 is invalid. The RTL stops elaboration via a generate-time check.

Test Plan:
- Defaults, write addr 0x123 data 0xA5 -> W low exactly 3 cycles, dq_oe high 5 cycles (T_AS+T_WP+T_DH), rsp_valid 5 cycles after accept; read 0x123 -> rsp_rdata=0xA5, rsp_valid 6 cycles after accept.
- Read of the unwritten location 0x7FF against the behavioural model -> rsp_rdata=0xFF; G low exactly 5 cycles; no cycle with dq_oe=1 and G low.
- Back-to-back: req_valid held high for 4 writes then 4 reads at 0x000-0x003 -> accepts spaced 9 cycles (writes) and 10 cycles (reads), data read back in order, E high >=3 cycles between accesses.
- ADDR_W=16, DATA_W=16, T_AS=2, T_RD=2, T_WP=4, T_DH=2, T_TURN=1 -> write 0xFFFF<=0xBEEF, read returns 0xBEEF; W low 4 cycles, read latency 4 cycles.
- rst_n pulled low in the 2nd cycle of WR_PULSE -> sram_w_n, sram_e_n=1 and sram_dq_oe=0 within the same cycle, before the next edge; no rsp_valid; req_ready=1 one cycle after release.
- req_valid toggling during RD_ACC with a changing req_addr -> sram_addr unchanged until RECOVER; only the originally accepted request is serviced.
